mips_ex_alu_arb: RTL and testbench

- Sequences the shared EX-stage ALU datapath between three requesters: regular ALU, AGU and BJP comparator.
- Fixed-priority/round-robin hybrid arbiter with anti-starvation counter.
- Drives the datapath request, operand and opcode inputs, and captures the result into a single-entry output register with a valid/ready handshake toward EX/MEM.

---
 rtl/mips_ex_alu_arb.sv | 164 ++++++++++++++++
 tb/tb_mips_ex_alu_arb.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/mips_ex_alu_arb.sv
// EX-stage shared ALU arbiter.
// Three requesters share one EX datapath: the regular ALU, the AGU and the
// BJP comparator. BJP normally has priority over ALU/AGU. ALU and AGU take
// turns round-robin. A starve counter promotes ALU/AGU over BJP once BJP has
// won STARVE_LIMIT times in a row while ALU/AGU was waiting. The datapath
// result is captured into a single-entry valid/ready output register.
module mips_ex_alu_arb #(
  parameter int DW           = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          alu_valid,
  output logic          alu_ready,
  input  logic [DW-1:0] alu_op1,
  input  logic [DW-1:0] alu_op2,
  input  logic [13:0]   alu_op,
  input  logic          agu_valid,
  output logic          agu_ready,
  input  logic [DW-1:0] agu_op1,
  input  logic [DW-1:0] agu_op2,
  input  logic          bjp_valid,
  output logic          bjp_ready,
  input  logic [DW-1:0] bjp_op1,
  input  logic [DW-1:0] bjp_op2,
  input  logic [5:0]    bjp_cmp,
  output logic          dp_alu_req,
  output logic          dp_agu_req,
  output logic          dp_bjp_req,
  output logic [DW-1:0] dp_op1,
  output logic [DW-1:0] dp_op2,
  output logic [13:0]   dp_alu_op,
  output logic [5:0]    dp_bjp_cmp,
  input  logic [DW-1:0] dp_res,
  input  logic          dp_cmp_res,
  output logic          o_valid,
  input  logic          o_ready,
  output logic [DW-1:0] o_res,
  output logic          o_cmp,
  output logic [1:0]    o_src,
  output logic          o_err
);

  localparam logic [3:0] LIM     = 4'(STARVE_LIMIT);
  localparam logic [1:0] SRC_ALU = 2'd0;
  localparam logic [1:0] SRC_AGU = 2'd1;
  localparam logic [1:0] SRC_BJP = 2'd2;

  // rr_q: 0 = ALU is next in the ALU/AGU round-robin, 1 = AGU
  logic [3:0]    starve_q, starve_d;
  logic          rr_q, rr_d;
  logic          o_valid_q, o_valid_d;
  logic [DW-1:0] o_res_q, o_res_d;
  logic          o_cmp_q, o_cmp_d;
  logic [1:0]    o_src_q, o_src_d;
  logic          o_err_q, o_err_d;

  logic can_accept, grant_en, aa_valid, promoted, pick_agu;
  logic gnt_alu, gnt_agu, gnt_bjp, gnt_aa, gnt_any, illegal;
  logic [1:0] src;

  // Grant decision: at most one winner, nothing while blocked or flushing
  always_comb begin
    can_accept = ~o_valid_q | o_ready;
    grant_en   = can_accept & ~flush;
    aa_valid   = alu_valid | agu_valid;
    promoted   = aa_valid & (starve_q == LIM);
    pick_agu   = agu_valid & (~alu_valid | rr_q);
    gnt_bjp    = grant_en & bjp_valid & ~promoted;
    gnt_aa     = grant_en & aa_valid & ~gnt_bjp;
    gnt_alu    = gnt_aa & ~pick_agu;
    gnt_agu    = gnt_aa & pick_agu;
    gnt_any    = gnt_aa | gnt_bjp;
    illegal    = (gnt_alu & ~$onehot(alu_op)) | (gnt_bjp & ~$onehot(bjp_cmp));
    src        = gnt_bjp ? SRC_BJP : (gnt_agu ? SRC_AGU : SRC_ALU);
  end

  assign alu_ready  = gnt_alu;
  assign agu_ready  = gnt_agu;
  assign bjp_ready  = gnt_bjp;
  assign dp_alu_req = gnt_alu;
  assign dp_agu_req = gnt_agu;
  assign dp_bjp_req = gnt_bjp;

  // Datapath drive: only the winner's fields, zero otherwise (AGU opcode stays 0)
  always_comb begin
    dp_op1     = '0;
    dp_op2     = '0;
    dp_alu_op  = '0;
    dp_bjp_cmp = '0;
    if (gnt_alu) begin
      dp_op1    = alu_op1;
      dp_op2    = alu_op2;
      dp_alu_op = alu_op;
    end else if (gnt_agu) begin
      dp_op1 = agu_op1;
      dp_op2 = agu_op2;
    end else if (gnt_bjp) begin
      dp_op1     = bjp_op1;
      dp_op2     = bjp_op2;
      dp_bjp_cmp = bjp_cmp;
    end
  end

  // Next state for starve counter, round-robin pointer and output register
  always_comb begin
    starve_d  = starve_q;
    rr_d      = rr_q;
    o_valid_d = o_valid_q;
    o_res_d   = o_res_q;
    o_cmp_d   = o_cmp_q;
    o_src_d   = o_src_q;
    o_err_d   = o_err_q;

    if (flush || !aa_valid || gnt_aa)
      starve_d = '0;
    else if (gnt_bjp && (starve_q != LIM))
      starve_d = starve_q + 4'd1;

    if (gnt_alu)
      rr_d = 1'b1;
    else if (gnt_agu)
      rr_d = 1'b0;

    if (gnt_any) begin
      o_valid_d = 1'b1;
      o_res_d   = illegal ? '0 : dp_res;
      o_cmp_d   = gnt_bjp & ~illegal & dp_cmp_res;
      o_src_d   = src;
      o_err_d   = illegal;
    end else if (flush || o_ready) begin
      o_valid_d = 1'b0;
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      starve_q  <= '0;
      rr_q      <= 1'b0;
      o_valid_q <= 1'b0;
      o_res_q   <= '0;
      o_cmp_q   <= 1'b0;
      o_src_q   <= SRC_ALU;
      o_err_q   <= 1'b0;
    end else begin
      starve_q  <= starve_d;
      rr_q      <= rr_d;
      o_valid_q <= o_valid_d;
      o_res_q   <= o_res_d;
      o_cmp_q   <= o_cmp_d;
      o_src_q   <= o_src_d;
      o_err_q   <= o_err_d;
    end
  end

  assign o_valid = o_valid_q;
  assign o_res   = o_res_q;
  assign o_cmp   = o_cmp_q;
  assign o_src   = o_src_q;
  assign o_err   = o_err_q;

endmodule

// File: tb/tb_mips_ex_alu_arb.sv
// Directed testbench for mips_ex_alu_arb. The datapath is modelled as an
// adder with an equality compare so captured results are predictable.
module tb_mips_ex_alu_arb;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n, flush;
  logic          alu_valid, alu_ready, agu_valid, agu_ready, bjp_valid, bjp_ready;
  logic [DW-1:0] alu_op1, alu_op2, agu_op1, agu_op2, bjp_op1, bjp_op2;
  logic [13:0]   alu_op;
  logic [5:0]    bjp_cmp;
  logic          dp_alu_req, dp_agu_req, dp_bjp_req;
  logic [DW-1:0] dp_op1, dp_op2, dp_res;
  logic [13:0]   dp_alu_op;
  logic [5:0]    dp_bjp_cmp;
  logic          dp_cmp_res;
  logic          o_valid, o_ready, o_cmp, o_err;
  logic [DW-1:0] o_res;
  logic [1:0]    o_src;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign dp_res     = dp_op1 + dp_op2;
  assign dp_cmp_res = (dp_op1 == dp_op2);

  mips_ex_alu_arb #(.DW(DW), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_op(alu_op),
    .agu_valid(agu_valid), .agu_ready(agu_ready), .agu_op1(agu_op1), .agu_op2(agu_op2),
    .bjp_valid(bjp_valid), .bjp_ready(bjp_ready), .bjp_op1(bjp_op1), .bjp_op2(bjp_op2), .bjp_cmp(bjp_cmp),
    .dp_alu_req(dp_alu_req), .dp_agu_req(dp_agu_req), .dp_bjp_req(dp_bjp_req),
    .dp_op1(dp_op1), .dp_op2(dp_op2), .dp_alu_op(dp_alu_op), .dp_bjp_cmp(dp_bjp_cmp),
    .dp_res(dp_res), .dp_cmp_res(dp_cmp_res),
    .o_valid(o_valid), .o_ready(o_ready), .o_res(o_res), .o_cmp(o_cmp), .o_src(o_src), .o_err(o_err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic idle_inputs;
    flush = 0; o_ready = 0;
    alu_valid = 0; alu_op1 = 0; alu_op2 = 0; alu_op = 0;
    agu_valid = 0; agu_op1 = 0; agu_op2 = 0;
    bjp_valid = 0; bjp_op1 = 0; bjp_op2 = 0; bjp_cmp = 0;
  endtask

  int exp_seq [10] = '{2, 2, 2, 2, 0, 2, 2, 2, 2, 1};

  initial begin
    idle_inputs();
    do_reset();
    #1;
    chk("rst_o_valid", 64'(o_valid), 64'd0);
    chk("rst_o_res", 64'(o_res), 64'd0);
    chk("rst_o_src", 64'(o_src), 64'd0);
    chk("rst_o_err", 64'(o_err), 64'd0);
    chk("rst_ready", 64'({alu_ready, agu_ready, bjp_ready}), 64'd0);
    chk("rst_dp", 64'({dp_alu_req, dp_agu_req, dp_bjp_req, dp_op1}), 64'd0);

    // ALU add 5 + 7
    alu_valid = 1; alu_op1 = 5; alu_op2 = 7; alu_op = 14'b1; o_ready = 1;
    #1;
    chk("alu_ready_c0", 64'(alu_ready), 64'd1);
    chk("alu_dp_op", 64'({dp_alu_req, dp_alu_op}), 64'h4001);
    tick();
    alu_valid = 0;
    chk("alu_o_valid", 64'(o_valid), 64'd1);
    chk("alu_o_res", 64'(o_res), 64'd12);
    chk("alu_o_src", 64'(o_src), 64'd0);
    tick();
    chk("alu_drain", 64'(o_valid), 64'd0);

    // ALU and AGU round-robin
    do_reset();
    alu_valid = 1; alu_op1 = 1; alu_op2 = 2; alu_op = 14'b1;
    agu_valid = 1; agu_op1 = 32'h100; agu_op2 = 32'h20; o_ready = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("rr_ready", 64'({alu_ready, agu_ready}), (i % 2 == 0) ? 64'b10 : 64'b01);
      chk("rr_agu_op_zero", 64'(dp_alu_op), (i % 2 == 0) ? 64'h1 : 64'h0);
      tick();
      chk("rr_o_valid", 64'(o_valid), 64'd1);
      chk("rr_o_src", 64'(o_src), 64'(i % 2));
      chk("rr_o_res", 64'(o_res), (i % 2 == 0) ? 64'd3 : 64'h120);
    end
    alu_valid = 0; agu_valid = 0;
    tick();
    chk("rr_drain", 64'(o_valid), 64'd0);

    // Starvation promotion
    do_reset();
    alu_valid = 1; agu_valid = 1; bjp_valid = 1;
    bjp_op1 = 3; bjp_op2 = 4; bjp_cmp = 6'b000100; o_ready = 1;
    for (int i = 0; i < 10; i++) begin
      #1;
      chk("starve_grant", 64'({bjp_ready, agu_ready, alu_ready}),
          (exp_seq[i] == 2) ? 64'b100 : ((exp_seq[i] == 1) ? 64'b010 : 64'b001));
      tick();
      chk("starve_o_src", 64'(o_src), 64'(exp_seq[i]));
    end
    alu_valid = 0; agu_valid = 0; bjp_valid = 0;
    tick();

    // Backpressure
    do_reset();
    alu_valid = 1; alu_op1 = 10; alu_op2 = 20; alu_op = 14'b1; o_ready = 0;
    #1;
    chk("bp_first_ready", 64'(alu_ready), 64'd1);
    tick();
    chk("bp_first_res", 64'({o_valid, o_res}), {31'd0, 1'b1, 32'd30});
    alu_op1 = 40;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_hold_ready", 64'(alu_ready), 64'd0);
      tick();
      chk("bp_hold_res", 64'({o_valid, o_res}), {31'd0, 1'b1, 32'd30});
    end
    o_ready = 1;
    #1;
    chk("bp_drain_grant", 64'(alu_ready), 64'd1);
    tick();
    alu_valid = 0;
    chk("bp_new_res", 64'({o_valid, o_res}), {31'd0, 1'b1, 32'd60});
    tick();
    chk("bp_empty", 64'(o_valid), 64'd0);

    // BJP compare and illegal opcodes
    bjp_valid = 1; bjp_op1 = 32'h10; bjp_op2 = 32'h10; bjp_cmp = 6'b000100;
    tick();
    chk("bjp_eq", 64'({o_valid, o_cmp, o_src, o_err}), 64'b11100);
    chk("bjp_res", 64'(o_res), 64'h20);
    bjp_cmp = 6'b000011;
    tick();
    chk("bjp_illegal", 64'({o_valid, o_cmp, o_src, o_err}), 64'b10101);
    chk("bjp_illegal_res", 64'(o_res), 64'd0);
    bjp_valid = 0;
    alu_valid = 1; alu_op1 = 9; alu_op2 = 9; alu_op = 14'd0;
    tick();
    chk("alu_illegal", 64'({o_valid, o_cmp, o_src, o_err}), 64'b10001);
    chk("alu_illegal_res", 64'(o_res), 64'd0);
    alu_op = 14'b1;
    tick();
    chk("alu_cmp_zero", 64'({o_cmp, o_err, o_res}), 64'd18);

    // Flush
    alu_valid = 1; alu_op1 = 2; alu_op2 = 2; o_ready = 1; flush = 1;
    #1;
    chk("flush_no_ready", 64'({alu_ready, dp_alu_req}), 64'd0);
    tick();
    flush = 0;
    chk("flush_kill", 64'(o_valid), 64'd0);
    #1;
    chk("flush_after_grant", 64'(alu_ready), 64'd1);
    tick();
    alu_valid = 0;
    chk("flush_after_res", 64'({o_valid, o_res}), {31'd0, 1'b1, 32'd4});

    // Reset mid-transfer
    o_ready = 0; alu_valid = 1;
    tick();
    alu_valid = 0;
    rst_n = 0;
    tick();
    chk("rst_mid", 64'({o_valid, o_res}), 64'd0);
    rst_n = 1;
    tick();
    chk("rst_mid_quiet", 64'(o_valid), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
